// File: rtl/dffram_read_streamer_pkg.sv
// Shared types for the DFFRAM port-1 read streamer: FSM state encoding and skid FIFO sizing.
package dffram_read_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = 2;

endpackage

// File: rtl/dffram_read_streamer_skid_fifo.sv
// Two-entry skid FIFO (module stream_skid_fifo) holding RAM words plus their last flag.
// The head entry drives the stream directly; push and pop in one cycle keep the count.
module stream_skid_fifo
    import dffram_read_streamer_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      din_i,
    output logic [WIDTH-1:0]      head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [FIFO_CNT_W-1:0] count_o
);

    localparam logic [FIFO_CNT_W-1:0] CNT_ONE  = FIFO_CNT_W'(1);
    localparam logic [FIFO_CNT_W-1:0] CNT_FULL = FIFO_CNT_W'(FIFO_DEPTH);

    logic [WIDTH-1:0]      head_q;
    logic [WIDTH-1:0]      tail_q;
    logic [FIFO_CNT_W-1:0] count_q;
    logic                  pop_ok;
    logic                  push_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != CNT_FULL) || pop_ok);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == '0) begin
                        head_q <= din_i;
                    end else begin
                        tail_q <= din_i;
                    end
                    count_q <= count_q + CNT_ONE;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - CNT_ONE;
                end
                2'b11: begin
                    // Head leaves and the new word slots in behind whatever remains.
                    if (count_q == CNT_ONE) begin
                        head_q <= din_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_o  = head_q;
    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/dffram_read_streamer.sv
// Reads len words from DFFRAM port 1 starting at base_addr and streams them out valid/ready.
// Build macro STREAMER_WRAP_EN: burst repeats from base_addr until a start pulse stops it.
module dffram_read_streamer
    import dffram_read_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  csb1_o,
    output logic [ADDR_WIDTH-1:0] addr1_o,
    input  logic [DATA_WIDTH-1:0] dout1_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [FIFO_CNT_W-1:0] CNT_ONE  = FIFO_CNT_W'(1);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     left_q;
    logic                    inflight_q;
    logic                    inflight_last_q;
`ifdef STREAMER_WRAP_EN
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH:0]     len_q;
`endif

    logic [DATA_WIDTH:0]     fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FIFO_CNT_W-1:0]   fifo_count;
    logic                    pop;
    logic                    issue;
    logic                    stop_req;
    logic                    last_issue;
    logic                    drained;
    logic [2:0]              occ;

    assign pop = !fifo_empty && out_ready_i;

    // Slots already spoken for once this cycle's pop leaves: buffered words plus the read in flight.
    assign occ = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

`ifdef STREAMER_WRAP_EN
    assign stop_req = start_i;
`else
    assign stop_req = 1'b0;
`endif

    assign issue      = (state_q == ST_RUN) && !stop_req && (occ < 3'd2)
                        && !(fifo_full && !pop);
    assign last_issue = (left_q == LEN_ONE);
    assign drained    = !inflight_q && (fifo_empty || (pop && fifo_count == CNT_ONE));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            left_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
`ifdef STREAMER_WRAP_EN
            base_q          <= '0;
            len_q           <= '0;
`endif
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && last_issue;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        addr_q <= base_addr_i;
                        left_q <= len_i;
`ifdef STREAMER_WRAP_EN
                        base_q <= base_addr_i;
                        len_q  <= len_i;
`endif
                        state_q <= (len_i == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop_req) begin
                        state_q <= ST_DRAIN;
                    end else if (issue) begin
                        if (last_issue) begin
`ifdef STREAMER_WRAP_EN
                            addr_q <= base_q;
                            left_q <= len_q;
`else
                            addr_q  <= addr_q + ADDR_ONE;
                            left_q  <= left_q - LEN_ONE;
                            state_q <= ST_DRAIN;
`endif
                        end else begin
                            addr_q <= addr_q + ADDR_ONE;
                            left_q <= left_q - LEN_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    stream_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .din_i   ({inflight_last_q, dout1_i}),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o      = (state_q == ST_DONE);
    assign csb1_o      = !issue;
    assign addr1_o     = addr_q;
    assign out_valid_o = !fifo_empty;
    assign out_data_o  = fifo_head[DATA_WIDTH-1:0];
    assign out_last_o  = fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_dffram_read_streamer.sv
// Self-checking bench for dffram_read_streamer with a behavioural RAM and stream scoreboard.
module tb_dffram_read_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  len = '0;
    logic        busy, done, csb1, out_valid, out_last;
    logic [7:0]  addr1;
    logic [31:0] dout1 = '0;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad = 0;

    dffram_read_streamer #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .base_addr_i(base_addr), .len_i(len),
        .busy_o(busy), .done_o(done), .csb1_o(csb1), .addr1_o(addr1), .dout1_i(dout1),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_last_o(out_last)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    always @(posedge clk) if (!csb1) dout1 <= mem[addr1];

    // Observation record, sampled mid-cycle.
    int          ncyc = 0, start_n = 0, iss_total = 0, acc_total = 0, occ_err = 0, stab_err = 0;
    logic [7:0]  iss_addr [$];
    int          iss_cyc  [$];
    logic [31:0] beat_data[$];
    logic        beat_last[$];
    int          beat_cyc [$];
    int          done_cyc [$];
    logic        pv = 0, pr = 0, pl = 0;
    logic [31:0] pd = '0;

    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            iss_total = 0; acc_total = 0; pv = 0;
        end else begin
            if (start && !busy) start_n = ncyc;
            if (!csb1) begin iss_addr.push_back(addr1); iss_cyc.push_back(ncyc); iss_total++; end
            if (out_valid && out_ready) begin
                beat_data.push_back(out_data); beat_last.push_back(out_last);
                beat_cyc.push_back(ncyc); acc_total++;
            end
            if (done) done_cyc.push_back(ncyc);
            if (iss_total - acc_total > 2 || iss_total < acc_total) occ_err++;
            if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) stab_err++;
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
        end
    end

    int ready_mode = 0;
    int ready_idx = 0;

    task automatic step();
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (ready_idx % 4 == 0) || (ready_idx % 4 == 3); ready_idx++; end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic do_burst(input int b, input int l, input int stop_at, output int s, output bit to);
        int n = 0;
        int d0 = done_cyc.size();
        step();
        start = 1'b1; base_addr = 8'(b); len = 9'(l);
        step();
        start = 1'b0; base_addr = 8'($urandom); len = 9'($urandom_range(0, 511));
        while (done_cyc.size() == d0 && n < 3000) begin
            start = (n == stop_at);
            step();
            n++;
        end
        start = 1'b0;
        to = (done_cyc.size() == d0);
        s = start_n;
    endtask

    // Compares what was observed since the given queue marks against the reference burst.
    task automatic score(input int b, input int l, input int i0, input int b0, input bit wrap,
                         output int n_iss, output int n_beat, output int ae, output int de,
                         output int le);
        n_iss = iss_addr.size() - i0;
        n_beat = beat_data.size() - b0;
        ae = 0; de = 0; le = 0;
        for (int k = 0; k < n_iss; k++) begin
            logic [7:0] ea;
            ea = 8'(wrap ? (b + k % l) : (b + k));
            if (iss_addr[i0 + k] !== ea) ae++;
        end
        for (int k = 0; k < n_beat; k++) begin
            logic [7:0] ea;
            logic el;
            ea = 8'(wrap ? (b + k % l) : (b + k));
            el = wrap ? (k % l == l - 1) : (k == l - 1);
            if (beat_data[b0 + k] !== mem[ea]) de++;
            if (beat_last[b0 + k] !== el) le++;
        end
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0d exp=0", done); end
        total++; if (csb1 !== 1'b1) begin bad++; $display("FAIL reset_csb1 got=%0d exp=1", csb1); end
        total++; if (addr1 !== 8'h00) begin bad++; $display("FAIL reset_addr1 got=%0h exp=0", addr1); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d exp=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%0d exp=0", out_last); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%0h exp=0", out_data); end
    endtask

    task automatic test_basic();
        int s, n_iss, n_beat, ae, de, le;
        int i0 = iss_addr.size(), b0 = beat_data.size(), d0 = done_cyc.size();
        bit to;
        ready_mode = 0;
        do_burst(16, 4, -1, s, to);
        score(16, 4, i0, b0, 0, n_iss, n_beat, ae, de, le);
        total++; if (to) begin bad++; $display("FAIL basic_timeout got=no_done exp=done"); end
        total++; if (n_iss !== 4) begin bad++; $display("FAIL basic_issues got=%0d exp=4", n_iss); end
        total++; if (ae !== 0) begin bad++; $display("FAIL basic_addr got=%0d_bad exp=0", ae); end
        total++; if (iss_cyc[i0] !== s + 1) begin bad++; $display("FAIL basic_first_issue got=%0d exp=%0d", iss_cyc[i0], s + 1); end
        total++; if (iss_cyc[i0 + 3] !== s + 4) begin bad++; $display("FAIL basic_issue_run got=%0d exp=%0d", iss_cyc[i0 + 3], s + 4); end
        total++; if (n_beat !== 4) begin bad++; $display("FAIL basic_beats got=%0d exp=4", n_beat); end
        total++; if (de !== 0 || le !== 0) begin bad++; $display("FAIL basic_data got=%0d/%0d exp=0/0", de, le); end
        total++; if (beat_cyc[b0] !== s + 3) begin bad++; $display("FAIL basic_first_valid got=%0d exp=%0d", beat_cyc[b0], s + 3); end
        total++; if (beat_cyc[b0 + 3] !== s + 6) begin bad++; $display("FAIL basic_consecutive got=%0d exp=%0d", beat_cyc[b0 + 3], s + 6); end
        total++; if (done_cyc[d0] !== s + 7) begin bad++; $display("FAIL basic_done got=%0d exp=%0d", done_cyc[d0], s + 7); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%0d exp=0", busy); end
    endtask

    task automatic test_backpressure();
        int s, n_iss, n_beat, ae, de, le, b;
        int i0 = iss_addr.size(), b0 = beat_data.size(), d0 = done_cyc.size();
        bit to;
        b = $urandom_range(0, 255);
        ready_mode = 1; ready_idx = 0;
        do_burst(b, 8, -1, s, to);
        score(b, 8, i0, b0, 0, n_iss, n_beat, ae, de, le);
        total++; if (to) begin bad++; $display("FAIL bp_timeout got=no_done exp=done"); end
        total++; if (n_iss !== 8 || ae !== 0) begin bad++; $display("FAIL bp_issues got=%0d/%0d exp=8/0", n_iss, ae); end
        total++; if (n_beat !== 8) begin bad++; $display("FAIL bp_beats got=%0d exp=8", n_beat); end
        total++; if (de !== 0 || le !== 0) begin bad++; $display("FAIL bp_data got=%0d/%0d exp=0/0", de, le); end
        total++; if (iss_cyc[i0 + 7] - iss_cyc[i0] < 8) begin bad++; $display("FAIL bp_no_stall got=%0d exp=>=8", iss_cyc[i0 + 7] - iss_cyc[i0]); end
        total++; if (done_cyc[d0] !== beat_cyc[b0 + 7] + 1) begin bad++; $display("FAIL bp_done got=%0d exp=%0d", done_cyc[d0], beat_cyc[b0 + 7] + 1); end
        total++; if (occ_err !== 0) begin bad++; $display("FAIL bp_occupancy got=%0d exp=0", occ_err); end
        total++; if (stab_err !== 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stab_err); end
    endtask

    task automatic test_addr_wrap();
        int s, n_iss, n_beat, ae, de, le, b;
        int i0 = iss_addr.size(), b0 = beat_data.size();
        bit to;
        ready_mode = 0;
        do_burst(254, 4, -1, s, to);
        score(254, 4, i0, b0, 0, n_iss, n_beat, ae, de, le);
        total++; if (to || n_iss !== 4 || ae !== 0) begin bad++; $display("FAIL wrap4_addr got=%0d/%0d exp=4/0", n_iss, ae); end
        total++; if (iss_addr[i0 + 2] !== 8'h00) begin bad++; $display("FAIL wrap4_zero got=%0h exp=0", iss_addr[i0 + 2]); end
        total++; if (de !== 0 || le !== 0) begin bad++; $display("FAIL wrap4_data got=%0d/%0d exp=0/0", de, le); end
        b = $urandom_range(0, 255);
        i0 = iss_addr.size(); b0 = beat_data.size();
        ready_mode = 2;
        do_burst(b, 256, -1, s, to);
        score(b, 256, i0, b0, 0, n_iss, n_beat, ae, de, le);
        total++; if (to || n_beat !== 256) begin bad++; $display("FAIL full_beats got=%0d exp=256", n_beat); end
        total++; if (de !== 0 || le !== 0 || ae !== 0) begin bad++; $display("FAIL full_data got=%0d/%0d/%0d exp=0/0/0", de, le, ae); end
        total++; if (iss_addr[i0 + 255] !== 8'(b - 1)) begin bad++; $display("FAIL full_end_addr got=%0h exp=%0h", iss_addr[i0 + 255], 8'(b - 1)); end
    endtask

    task automatic test_len_zero();
        int s;
        int i0 = iss_addr.size(), b0 = beat_data.size(), d0 = done_cyc.size();
        bit to;
        ready_mode = 0;
        do_burst(33, 0, -1, s, to);
        total++; if (to) begin bad++; $display("FAIL len0_timeout got=no_done exp=done"); end
        total++; if (iss_addr.size() !== i0) begin bad++; $display("FAIL len0_issues got=%0d exp=0", iss_addr.size() - i0); end
        total++; if (done_cyc[d0] !== s + 1) begin bad++; $display("FAIL len0_done got=%0d exp=%0d", done_cyc[d0], s + 1); end
        total++; if (beat_data.size() !== b0) begin bad++; $display("FAIL len0_valid got=%0d exp=0", beat_data.size() - b0); end
    endtask

    task automatic test_busy_start();
        int s, n_iss, n_beat, ae, de, le;
        int i0 = iss_addr.size(), b0 = beat_data.size();
        bit to;
        ready_mode = 0;
        do_burst(100, 6, 2, s, to);
        score(100, 6, i0, b0, 0, n_iss, n_beat, ae, de, le);
        total++; if (to || n_iss !== 6 || ae !== 0) begin bad++; $display("FAIL busy_start_issues got=%0d/%0d exp=6/0", n_iss, ae); end
        total++; if (n_beat !== 6 || de !== 0 || le !== 0) begin bad++; $display("FAIL busy_start_data got=%0d/%0d/%0d exp=6/0/0", n_beat, de, le); end
    endtask

    task automatic test_reset_mid();
        int d0, i0, b0, n_iss, n_beat, ae, de, le, s;
        bit to;
        ready_mode = 2;
        step();
        start = 1'b1; base_addr = 8'd40; len = 9'd20;
        step();
        start = 1'b0;
        repeat (4) step();
        d0 = done_cyc.size();
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0d/%0d exp=0/0", busy, done); end
        total++; if (csb1 !== 1'b1 || addr1 !== 8'h00) begin bad++; $display("FAIL midrst_ram got=%0d/%0h exp=1/0", csb1, addr1); end
        total++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0) begin bad++; $display("FAIL midrst_stream got=%0d/%0d/%0h exp=0/0/0", out_valid, out_last, out_data); end
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        total++; if (done_cyc.size() !== d0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", done_cyc.size() - d0); end
        i0 = iss_addr.size(); b0 = beat_data.size();
        do_burst(7, 3, -1, s, to);
        score(7, 3, i0, b0, 0, n_iss, n_beat, ae, de, le);
        total++; if (to || n_beat !== 3 || de !== 0 || le !== 0) begin bad++; $display("FAIL midrst_recover got=%0d/%0d/%0d exp=3/0/0", n_beat, de, le); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            int s, n_iss, n_beat, ae, de, le, b, l;
            int i0 = iss_addr.size(), b0 = beat_data.size(), d0 = done_cyc.size();
            bit to;
            b = $urandom_range(0, 255);
            l = $urandom_range(1, 24);
            ready_mode = 2;
            do_burst(b, l, -1, s, to);
            score(b, l, i0, b0, 0, n_iss, n_beat, ae, de, le);
            total++; if (to || n_beat !== l || n_iss !== l) begin bad++; $display("FAIL rand%0d_count got=%0d/%0d exp=%0d", r, n_iss, n_beat, l); end
            total++; if (de !== 0 || le !== 0 || ae !== 0) begin bad++; $display("FAIL rand%0d_data got=%0d/%0d/%0d exp=0/0/0", r, de, le, ae); end
            total++; if (done_cyc[d0] !== beat_cyc[b0 + l - 1] + 1) begin bad++; $display("FAIL rand%0d_done got=%0d exp=%0d", r, done_cyc[d0], beat_cyc[b0 + l - 1] + 1); end
        end
        total++; if (occ_err !== 0 || stab_err !== 0) begin bad++; $display("FAIL rand_protocol got=%0d/%0d exp=0/0", occ_err, stab_err); end
    endtask

`ifdef STREAMER_WRAP_EN
    task automatic test_wrap();
        int n = 0, n_iss, n_beat, ae, de, le, d0;
        int i0 = iss_addr.size(), b0 = beat_data.size();
        ready_mode = 0;
        d0 = done_cyc.size();
        step();
        start = 1'b1; base_addr = 8'd50; len = 9'd3;
        step();
        start = 1'b0;
        while (beat_data.size() - b0 < 9 && n < 200) begin step(); n++; end
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (done_cyc.size() == d0 && n < 200) begin step(); n++; end
        score(50, 3, i0, b0, 1, n_iss, n_beat, ae, de, le);
        total++; if (done_cyc.size() == d0) begin bad++; $display("FAIL wrap_done got=no_done exp=done"); end
        total++; if (n_beat < 9 || n_beat !== n_iss) begin bad++; $display("FAIL wrap_count got=%0d/%0d exp=equal>=9", n_iss, n_beat); end
        total++; if (ae !== 0 || de !== 0 || le !== 0) begin bad++; $display("FAIL wrap_data got=%0d/%0d/%0d exp=0/0/0", ae, de, le); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_busy got=%0d exp=0", busy); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) step();
        test_reset();
        rst_n = 1'b1;
        step();
`ifdef STREAMER_WRAP_EN
        test_len_zero();
        test_wrap();
        test_reset_mid();
`else
        test_basic();
        test_backpressure();
        test_addr_wrap();
        test_len_zero();
        test_busy_start();
        test_reset_mid();
        test_random();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
